// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, optionally times out memory waits, and counts retired instructions.
module multicycle_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             neg,
    input  logic             mem_ready,
    output logic             memread,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             regwrite,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             immzext,
    output logic             memtoreg,
    output logic [4:0]       destreg,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
        S_ERROR  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b111;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b000;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_NONE = 3'b010;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  instret_reg;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic [5:0] op, funct;
    logic [2:0] r_alu, i_alu;
    logic       r_valid, i_zext, waiting, timeout_hit;
    logic       unused_instr_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

    always_comb begin
        r_alu   = ALU_NONE;
        r_valid = 1'b1;
        case (funct)
            6'b100001: r_alu = ALU_ADD;
            6'b100011: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101011: r_alu = ALU_SLTU;
            default:   r_valid = 1'b0;
        endcase
    end

    always_comb begin
        i_alu  = ALU_NONE;
        i_zext = 1'b0;
        case (op)
            OP_ADDIU: i_alu = ALU_ADD;
            OP_ORI:   begin i_alu = ALU_OR; i_zext = 1'b1; end
            OP_LUI:   i_alu = ALU_LUI;
            default:  i_alu = ALU_NONE;
        endcase
    end

    // The wait counter only runs while a memory access is outstanding.
    assign waiting       = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    assign timeout_hit   = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt_reg == WAIT_LAST);
    assign wait_cnt_next = (waiting && !mem_ready) ? wait_cnt_reg + 1'b1 : '0;

    always_comb begin
        state_next = state_reg;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        immzext    = 1'b0;
        destreg    = 5'd0;
        alucontrol = ALU_NONE;
        case (state_reg)
            S_FETCH: begin
                memread    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_ERROR;
                end
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:             state_next = S_MEMADR;
                    OP_RTYPE:                 state_next = S_EXEC;
                    OP_BEQ, OP_BLTZ:          state_next = S_BRANCH;
                    OP_ADDIU, OP_ORI, OP_LUI: state_next = S_IEXEC;
                    OP_J:                     state_next = S_JUMP;
                    default:                  state_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready)        state_next = S_MEMWB;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                destreg    = instr[20:16];
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready)        state_next = S_FETCH;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = r_alu;
                state_next = r_valid ? S_ALUWB : S_ERROR;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                destreg    = instr[15:11];
                alucontrol = r_alu;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcwrite    = (op == OP_BEQ) ? zero : neg;
                state_next = S_FETCH;
            end
            S_IEXEC, S_IWB: begin
                // IWB keeps the IEXEC ALU setup so the result stays stable during writeback.
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = i_alu;
                immzext    = i_zext;
                if (state_reg == S_IWB) begin
                    regwrite   = 1'b1;
                    destreg    = instr[20:16];
                    state_next = S_FETCH;
                end else begin
                    state_next = S_IWB;
                end
            end
            S_JUMP: begin
                pcwrite    = 1'b1;
                pcsrc      = 2'b10;
                state_next = S_FETCH;
            end
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_FETCH;
            instret_reg  <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == S_FETCH && state_reg != S_FETCH)
                instret_reg <= instret_reg + 1'b1;
        end
    end

    assign state   = state_reg;
    assign illegal = (state_reg == S_ERROR);
    assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words are queued
// per instruction, then popped and compared against the DUT each cycle.
module tb_multicycle_controller;

    logic        clk, reset, zero, neg, mem_ready;
    logic [31:0] instr;
    logic        memread, memwrite, iord, irwrite, pcwrite, regwrite, alusrca, immzext, memtoreg, illegal;
    logic [1:0]  pcsrc, alusrcb;
    logic [4:0]  destreg;
    logic [2:0]  alucontrol;
    logic [3:0]  state;
    logic [31:0] instret;

    multicycle_controller #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .neg(neg), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .regwrite(regwrite), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .immzext(immzext),
        .memtoreg(memtoreg), .destreg(destreg), .alucontrol(alucontrol), .illegal(illegal),
        .state(state), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [25:0] dut_word;
    assign dut_word = {state, memread, memwrite, iord, irwrite, pcwrite, regwrite, memtoreg,
                       pcsrc, alusrca, alusrcb, immzext, destreg, alucontrol, illegal};

    typedef struct {
        logic [31:0] ins;
        logic        mr, z, n;
        logic [25:0] exp;
        string       tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    logic [31:0] exp_instret = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100001: return 3'b101;
            6'b100011: return 3'b001;
            6'b100100: return 3'b111;
            6'b100101: return 3'b110;
            6'b101011: return 3'b000;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control word for one cycle, built from the state table.
    function automatic logic [25:0] ew(input logic [3:0] s, input logic [31:0] ins,
                                       input logic mr, input logic z, input logic n);
        logic mrd, mwr, io, irw, pcw, rw, m2r, asa, imz, ill;
        logic [1:0] ps, asb;
        logic [4:0] dr;
        logic [2:0] ac;
        {mrd, mwr, io, irw, pcw, rw, m2r, asa, imz, ill} = '0;
        ps = 2'b00; asb = 2'b00; dr = 5'd0; ac = 3'b010;
        case (s)
            4'd0:  begin mrd = 1; asb = 2'b01; ac = 3'b101; irw = mr; pcw = mr; end
            4'd1:  begin asb = 2'b11; ac = 3'b101; end
            4'd2:  begin asa = 1; asb = 2'b10; ac = 3'b101; end
            4'd3:  begin mrd = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; dr = ins[20:16]; end
            4'd5:  begin mwr = 1; io = 1; end
            4'd6:  begin asa = 1; ac = r_alu(ins[5:0]); end
            4'd7:  begin rw = 1; dr = ins[15:11]; ac = r_alu(ins[5:0]); end
            4'd8:  begin asa = 1; ac = 3'b001; ps = 2'b01; pcw = (ins[31:26] == 6'b000100) ? z : n; end
            4'd9, 4'd10: begin
                asa = 1; asb = 2'b10;
                case (ins[31:26])
                    6'b001001: ac = 3'b101;
                    6'b001101: begin ac = 3'b110; imz = 1; end
                    6'b001111: ac = 3'b011;
                    default:   ac = 3'b010;
                endcase
                if (s == 4'd10) begin rw = 1; dr = ins[20:16]; end
            end
            4'd11: begin pcw = 1; ps = 2'b10; end
            4'd12: ill = 1;
            default: ;
        endcase
        return {s, mrd, mwr, io, irw, pcw, rw, m2r, ps, asa, asb, imz, dr, ac, ill};
    endfunction

    task automatic push(input logic [3:0] s, input logic [31:0] ins, input logic mr,
                        input logic z, input logic n);
        sb_entry_t e;
        e.ins = ins; e.mr = mr; e.z = z; e.n = n;
        e.exp = ew(s, ins, mr, z, n);
        e.tag = $sformatf("op%02h_st%0d", ins[31:26], s);
        sb_q.push_back(e);
    endtask

    task automatic push_errors(input logic [31:0] ins);
        for (int i = 0; i < 10; i++) push(4'd12, ins, 1'b1, 1'b0, 1'b0);
    endtask

    // Queues the expected state sequence of one instruction.
    task automatic push_instr(input logic [31:0] ins, input int fstall, input int mstall,
                              input logic z, input logic n);
        logic [5:0] op;
        op = ins[31:26];
        for (int i = 0; i < fstall; i++) push(4'd0, ins, 1'b0, z, n);
        push(4'd0, ins, 1'b1, z, n);
        push(4'd1, ins, 1'b1, z, n);
        case (op)
            6'b100011: begin
                push(4'd2, ins, 1'b1, z, n);
                for (int i = 0; i < mstall; i++) push(4'd3, ins, 1'b0, z, n);
                push(4'd3, ins, 1'b1, z, n);
                push(4'd4, ins, 1'b1, z, n);
                exp_instret++;
            end
            6'b101011: begin
                push(4'd2, ins, 1'b1, z, n);
                for (int i = 0; i < mstall; i++) push(4'd5, ins, 1'b0, z, n);
                push(4'd5, ins, 1'b1, z, n);
                exp_instret++;
            end
            6'b000000: begin
                push(4'd6, ins, 1'b1, z, n);
                if (r_alu(ins[5:0]) != 3'b010) begin
                    push(4'd7, ins, 1'b1, z, n);
                    exp_instret++;
                end else begin
                    push_errors(ins);
                end
            end
            6'b000100, 6'b000001: begin push(4'd8, ins, 1'b1, z, n); exp_instret++; end
            6'b001001, 6'b001101, 6'b001111: begin
                push(4'd9, ins, 1'b1, z, n);
                push(4'd10, ins, 1'b1, z, n);
                exp_instret++;
            end
            6'b000010: begin push(4'd11, ins, 1'b1, z, n); exp_instret++; end
            default:   push_errors(ins);
        endcase
    endtask

    task automatic drain();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            instr = e.ins; mem_ready = e.mr; zero = e.z; neg = e.n;
            @(negedge clk);
            check_val(e.tag, 64'(dut_word), 64'(e.exp));
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fstall, input int mstall,
                             input logic z, input logic n);
        int cyc;
        push_instr(ins, fstall, mstall, z, n);
        cyc = sb_q.size();
        drain();
        $display("instr %h fstall %0d mstall %0d z %0b n %0b cycles %0d instret %0d",
                 ins, fstall, mstall, z, n, cyc, instret);
    endtask

    task automatic check_instret(input string tag);
        check_val(tag, 64'(instret), 64'(exp_instret));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_instret = 0;
    endtask

    logic [5:0] rfuncts[4] = '{6'b100011, 6'b100100, 6'b100101, 6'b101011};

    initial begin
        reset = 1'b0; instr = '0; zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;
        #3;
        check_val("rst_state", 64'(state), 64'd0);
        check_val("rst_memread", 64'(memread), 64'd1);
        check_val("rst_instret", 64'(instret), 64'd0);
        check_val("rst_illegal", 64'(illegal), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_instr({6'b100011, 5'd1, 5'd5, 16'd4}, 0, 0, 1'b0, 1'b0);
        run_instr({6'b101011, 5'd1, 5'd6, 16'd8}, 0, 0, 1'b0, 1'b0);
        check_instret("instret_lwsw");

        run_instr({6'b000000, 5'd2, 5'd3, 5'd7, 5'd0, 6'b100001}, 3, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_instr({6'b000000, 5'd2, 5'd3, 5'(12 + i), 5'd0, rfuncts[i]}, 0, 0, 1'b0, 1'b0);
        run_instr({6'b100011, 5'd1, 5'd8, 16'd0}, 0, 2, 1'b0, 1'b0);
        run_instr({6'b101011, 5'd1, 5'd8, 16'd0}, 0, 1, 1'b0, 1'b0);
        check_instret("instret_rtype");

        run_instr({6'b000100, 5'd1, 5'd2, 16'd3}, 0, 0, 1'b1, 1'b0);
        run_instr({6'b000100, 5'd1, 5'd2, 16'd3}, 0, 0, 1'b0, 1'b1);
        run_instr({6'b000001, 5'd1, 5'd0, 16'hfffe}, 0, 0, 1'b0, 1'b1);
        run_instr({6'b001101, 5'd1, 5'd9, 16'h8000}, 0, 0, 1'b0, 1'b0);
        run_instr({6'b001111, 5'd0, 5'd10, 16'h1234}, 0, 0, 1'b0, 1'b0);
        run_instr({6'b001001, 5'd2, 5'd11, 16'hffff}, 0, 0, 1'b0, 1'b0);
        run_instr({6'b000010, 26'h10}, 0, 0, 1'b0, 1'b0);
        check_instret("instret_mix");

        // Abort a load while it waits in MEMRD; reset must act without a clock edge.
        push(4'd0, 32'h8C250004, 1'b1, 1'b0, 1'b0);
        push(4'd1, 32'h8C250004, 1'b1, 1'b0, 1'b0);
        push(4'd2, 32'h8C250004, 1'b1, 1'b0, 1'b0);
        push(4'd3, 32'h8C250004, 1'b0, 1'b0, 1'b0);
        drain();
        check_val("pre_rst_state", 64'(state), 64'd3);
        reset = 1'b0;
        #1;
        check_val("async_rst_state", 64'(state), 64'd0);
        check_val("async_rst_instret", 64'(instret), 64'd0);
        check_val("async_rst_memread", 64'(memread), 64'd1);
        check_val("async_rst_iord", 64'(iord), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_instret = 0;
        $display("reset during MEMRD applied");

        run_instr({6'b000010, 26'h20}, 0, 0, 1'b0, 1'b0);
        run_instr({6'b111111, 26'h0}, 0, 0, 1'b0, 1'b0);
        check_instret("instret_frozen_op");
        check_val("illegal_op", 64'(illegal), 64'd1);
        do_reset();

        run_instr({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000000}, 0, 0, 1'b0, 1'b0);
        check_instret("instret_frozen_funct");
        do_reset();

        // Memory never answers: four idle fetch cycles exhaust the timeout.
        for (int i = 0; i < 4; i++) push(4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(4'd12, 32'h0, 1'b0, 1'b0, 1'b0);
        drain();
        check_val("timeout_illegal", 64'(illegal), 64'd1);
        check_instret("instret_timeout");
        $display("fetch timeout sequence done");
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
